// File: rtl/array_sort_writer.sv
// In-place ascending signed bubble sorter over a small host-loaded register file.
// The sorted array is exposed through a combinational read port once done is high.
module array_sort_writer #(
  parameter int W  = 32,
  parameter int IW = 3
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          go,
  input  logic [IW:0]   length,
  input  logic          wr_en,
  input  logic [IW-1:0] wr_addr,
  input  logic [W-1:0]  wr_data,
  input  logic [IW-1:0] rd_addr,
  output logic [W-1:0]  rd_data,
  output logic          busy,
  output logic          done,
  output logic [15:0]   swaps
);

  localparam int N = 1 << IW;

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_SCAN,
    S_SWAP,
    S_PASSEND,
    S_DONE
  } state_t;

  state_t              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [IW-1:0]       limit_q, limit_d;
  logic                swapped_q, swapped_d;
  logic [15:0]         swaps_q, swaps_d;
  logic signed [W-1:0] mem_q [N];

  logic [IW:0]         len_c;
  logic [IW-1:0]       idx_nxt;
  logic signed [W-1:0] a_cur, a_nxt;
  logic                gt;
  logic                swap_en;
  logic                host_wr;

  function automatic logic [IW:0] clamp_len(input logic [IW:0] l);
    return (l > (IW+1)'(N)) ? (IW+1)'(N) : l;
  endfunction

  function automatic logic [15:0] sat_inc16(input logic [15:0] v);
    return (v == 16'hFFFF) ? v : v + 16'd1;
  endfunction

  assign len_c   = clamp_len(length);
  assign idx_nxt = idx_q + IW'(1);
  assign a_cur   = mem_q[idx_q];
  assign a_nxt   = mem_q[idx_nxt];
  assign gt      = a_cur > a_nxt;

  // A swap on an aborting reset edge is suppressed so the abort takes effect immediately.
  assign swap_en = (state_q == S_SWAP) && reset;
  assign host_wr = wr_en && ((state_q == S_IDLE) || (state_q == S_DONE));

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      limit_q   <= '0;
      swapped_q <= 1'b0;
      swaps_q   <= '0;
    end else begin
      state_q   <= state_d;
      idx_q     <= idx_d;
      limit_q   <= limit_d;
      swapped_q <= swapped_d;
      swaps_q   <= swaps_d;
    end
  end

  // Array storage is deliberately left out of reset.
  always_ff @(posedge clock) begin
    if (swap_en) begin
      mem_q[idx_q]   <= a_nxt;
      mem_q[idx_nxt] <= a_cur;
    end else if (host_wr) begin
      mem_q[wr_addr] <= wr_data;
    end
  end

  always_comb begin
    state_d   = state_q;
    idx_d     = idx_q;
    limit_d   = limit_q;
    swapped_d = swapped_q;
    swaps_d   = swaps_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (go) state_d = S_START;
      end
      S_START: begin
        idx_d     = '0;
        swaps_d   = '0;
        swapped_d = 1'b0;
        limit_d   = IW'(len_c - (IW+1)'(1));
        if (!go) state_d = (len_c <= (IW+1)'(1)) ? S_DONE : S_SCAN;
      end
      S_SCAN: begin
        if (gt) begin
          state_d = S_SWAP;
        end else if (idx_nxt == limit_q) begin
          state_d = S_PASSEND;
        end else begin
          idx_d = idx_nxt;
        end
      end
      S_SWAP: begin
        swapped_d = 1'b1;
        swaps_d   = sat_inc16(swaps_q);
        if (idx_nxt == limit_q) begin
          state_d = S_PASSEND;
        end else begin
          idx_d   = idx_nxt;
          state_d = S_SCAN;
        end
      end
      S_PASSEND: begin
        // A clean pass or a final one-pair pass means the prefix is sorted.
        if (!swapped_q || (limit_q == IW'(1))) begin
          state_d = S_DONE;
        end else begin
          limit_d   = limit_q - IW'(1);
          idx_d     = '0;
          swapped_d = 1'b0;
          state_d   = S_SCAN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign rd_data = mem_q[rd_addr];
  assign busy    = (state_q == S_SCAN) || (state_q == S_SWAP) || (state_q == S_PASSEND);
  assign done    = (state_q == S_DONE);
  assign swaps   = swaps_q;

endmodule

// File: tb/tb_array_sort_writer.sv
// Randomized and directed bench for array_sort_writer against a behavioural sort model.
module tb_array_sort_writer;

  localparam int W  = 32;
  localparam int IW = 3;
  localparam int N  = 1 << IW;

  logic          clock = 1'b0;
  logic          reset;
  logic          go;
  logic [IW:0]   length;
  logic          wr_en;
  logic [IW-1:0] wr_addr;
  logic [W-1:0]  wr_data;
  logic [IW-1:0] rd_addr;
  logic [W-1:0]  rd_data;
  logic          busy;
  logic          done;
  logic [15:0]   swaps;

  int n_cmp = 0;
  int n_bad = 0;
  int signed ref_a [N];

  array_sort_writer #(.W(W), .IW(IW)) dut (
    .clock   (clock),
    .reset   (reset),
    .go      (go),
    .length  (length),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_addr (rd_addr),
    .rd_data (rd_data),
    .busy    (busy),
    .done    (done),
    .swaps   (swaps)
  );

  always #5 clock = ~clock;

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int rnd_val();
    case ($urandom_range(0, 3))
      0:       return int'($urandom_range(0, 8)) - 4;
      1:       return ($urandom_range(0, 1) == 1) ? 32'sh7FFFFFFF : 32'sh80000000;
      default: return int'($urandom);
    endcase
  endfunction

  task automatic write_elem(input int addr, input int data);
    wr_en   = 1'b1;
    wr_addr = addr[IW-1:0];
    wr_data = data;
    @(negedge clock);
    wr_en = 1'b0;
    ref_a[addr] = data;
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_done"}, done, 0);
    check_eq({tag, "_swaps"}, swaps, 0);
  endtask

  // Expected results: sorted prefix by insertion sort, swaps as the inversion
  // count, and cycles from the pass rules (limit scans + swaps + 1 per pass).
  task automatic run_sort(input string tag, input int len, input int k,
                          input bit cowr, input int cw_addr, input int cw_data,
                          input bit inject);
    int L, exp_sw, exp_cyc, edges, busy_cnt, lim, sw_pass, j;
    int signed b [N];
    int signed s [N];
    int signed t;
    bit seen;
    L = (len > N) ? N : len;

    go     = 1'b1;
    length = len[IW:0];
    if (cowr) begin
      wr_en   = 1'b1;
      wr_addr = cw_addr[IW-1:0];
      wr_data = cw_data;
      ref_a[cw_addr] = cw_data;
    end
    @(negedge clock);
    wr_en = 1'b0;
    check_eq({tag, "_start_busy"}, busy, 0);
    check_eq({tag, "_start_done"}, done, 0);
    repeat (k - 1) @(negedge clock);
    go = 1'b0;

    exp_sw = 0;
    for (int x = 0; x < L; x++)
      for (int y = x + 1; y < L; y++)
        if (ref_a[x] > ref_a[y]) exp_sw++;
    s = ref_a;
    for (int x = 1; x < L; x++) begin
      t = s[x];
      j = x - 1;
      while (j >= 0 && s[j] > t) begin
        s[j+1] = s[j];
        j--;
      end
      s[j+1] = t;
    end
    b = ref_a;
    exp_cyc = 0;
    lim = L - 1;
    while (lim >= 1) begin
      sw_pass = 0;
      for (int x = 0; x < lim; x++) begin
        exp_cyc++;
        if (b[x] > b[x+1]) begin
          t = b[x]; b[x] = b[x+1]; b[x+1] = t;
          sw_pass++;
          exp_cyc++;
        end
      end
      exp_cyc++;
      if (sw_pass == 0 || lim == 1) break;
      lim--;
    end

    edges = -1;
    busy_cnt = 0;
    seen = 1'b0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clock);
      if (done) begin
        edges = c - 1;
        wr_en = 1'b0;
        seen = 1'b1;
        break;
      end
      if (busy) busy_cnt++;
      if (inject && busy && $urandom_range(0, 2) == 0) begin
        wr_en   = 1'b1;
        wr_addr = IW'($urandom_range(0, N - 1));
        wr_data = 99;
      end else begin
        wr_en = 1'b0;
      end
    end
    wr_en = 1'b0;
    check_eq({tag, "_done_seen"}, seen, 1);
    check_eq({tag, "_latency"}, edges, exp_cyc);
    check_eq({tag, "_busy_cycles"}, busy_cnt, exp_cyc);
    check_eq({tag, "_swaps"}, swaps, exp_sw);
    for (int x = 0; x < N; x++) begin
      rd_addr = x[IW-1:0];
      #1;
      check_eq({tag, "_elem"}, $signed(rd_data), s[x]);
    end
    ref_a = s;
    @(negedge clock);
    check_eq({tag, "_done_hold"}, done, 1);
    check_eq({tag, "_swaps_hold"}, swaps, exp_sw);
  endtask

  initial begin
    reset   = 1'b0;
    go      = 1'b0;
    length  = '0;
    wr_en   = 1'b0;
    wr_addr = '0;
    wr_data = '0;
    rd_addr = '0;
    for (int x = 0; x < N; x++) ref_a[x] = 0;

    repeat (2) @(negedge clock);
    check_outputs_zero("reset");
    reset = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clock);
      check_outputs_zero("idle");
    end

    for (int x = 0; x < N; x++) write_elem(x, (x < 4) ? x + 1 : rnd_val());
    run_sort("sorted", 4, 1, 1'b0, 0, 0, 1'b0);
    check_eq("sorted_swaps_const", swaps, 0);

    write_elem(0, 4); write_elem(1, 3); write_elem(2, 2); write_elem(3, 1);
    run_sort("reversed", 4, 2, 1'b0, 0, 0, 1'b1);
    check_eq("reversed_swaps_const", swaps, 6);

    write_elem(0, -1); write_elem(1, 5); write_elem(2, -3); write_elem(3, 5);
    run_sort("signed", 4, 1, 1'b0, 0, 0, 1'b1);
    check_eq("signed_swaps_const", swaps, 2);

    run_sort("len0", 0, 1, 1'b0, 0, 0, 1'b0);
    run_sort("len1", 1, 3, 1'b0, 0, 0, 1'b0);

    for (int x = 0; x < N; x++) write_elem(x, N - x);
    run_sort("cowrite", 8, 1, 1'b1, 7, 100, 1'b1);

    for (int r = 0; r < 20; r++) begin
      for (int x = 0; x < N; x++) write_elem(x, rnd_val());
      run_sort("rand", $urandom_range(0, 2 * N - 1), $urandom_range(1, 3), 1'b0, 0, 0, 1'b1);
    end

    for (int x = 0; x < N; x++) write_elem(x, 50 - x);
    go     = 1'b1;
    length = 4'(N);
    @(negedge clock);
    go = 1'b0;
    repeat (6) @(negedge clock);
    check_eq("abort_pre_busy", busy, 1);
    reset = 1'b0;
    @(negedge clock);
    check_outputs_zero("abort");
    reset = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clock);
      check_outputs_zero("abort_idle");
    end

    for (int x = 0; x < N; x++) write_elem(x, rnd_val());
    run_sort("post_abort", N, 1, 1'b0, 0, 0, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/array_sort_writer.md
# array_sort_writer

In-place bubble sorter: the writing counterpart of the array sort checker in Lab 3. It holds a small register-file array that the host loads through a write port. On a `go` handshake it sorts the first `length` elements into ascending signed order by repeated compare/swap passes. It then raises `done` and exposes the result through a read port, so the sort checker can consume the array directly.

## Interface
Parameters:
- `W`, 32, element width in bits (signed two's complement).
- `IW`, 3, index width; array depth N = 2**IW.

Ports (name, direction, width, meaning):
- `clock`  in  1  single clock; all state changes on the rising edge.
- `reset`  in  1  synchronous, active-low reset.
- `go`  in  1  start request; level-sensitive handshake as described under Operation.
- `length`  in  IW+1  number of valid elements, 0..N; sampled while in START.
- `wr_en`  in  1  host write strobe.
- `wr_addr`  in  IW  host write index.
- `wr_data`  in  W  host write data.
- `rd_addr`  in  IW  read index.
- `rd_data`  out  W  combinational read: `array[rd_addr]`.
- `busy`  out  1  high in SCAN, SWAP and PASSEND.
- `done`  out  1  high in DONE.
- `swaps`  out  16  number of swaps performed in the current or last run; saturates at 16'hFFFF.

## Operation
- States: IDLE, START, SCAN, SWAP, PASSEND, DONE. Exactly one state is active at a time.
- Reset (`reset`=0 at an edge) forces IDLE, clears `swaps`, the pass limit, the index and the swapped flag. Array contents are not cleared.
- The reset value of every output is 0: `busy`, `done`, `swaps`. `rd_data` reflects the array only.
- IDLE/DONE:
  - A host write with `wr_en`=1 updates `array[wr_addr]` at the edge.
  - `go`=1 moves to START.
  - DONE holds while `go`=0.
- START:
  - Latches `length`, clears `swaps`, and sets limit = length-1 and index i=0.
  - Stays in START while `go`=1.
  - When `go`=0: goes to DONE if length ≤ 1, otherwise to SCAN.
- SCAN: compares `array[i]` against `array[i+1]` as signed values.
  - If `array[i]` > `array[i+1]`: go to SWAP.
  - Otherwise, if i+1 = limit: go to PASSEND.
  - Otherwise: i ← i+1 and stay in SCAN.
- SWAP:
  - Exchanges `array[i]` and `array[i+1]` in one edge.
  - Sets the swapped flag and increments `swaps`, saturating.
  - Then, if i+1 = limit, go to PASSEND; otherwise i ← i+1 and return to SCAN.
- PASSEND:
  - If the swapped flag is 0 or limit = 1: go to DONE.
  - Otherwise: limit ← limit-1, i ← 0, clear the swapped flag, and return to SCAN.
- Writes with `wr_en`=1 in START, SCAN, SWAP or PASSEND are ignored. They never corrupt the sort.
- Equal elements are never swapped, so the sort is stable.
- `length` > N is clamped to N.

## Timing
- `go` is asserted, held for k ≥ 1 cycles, then dropped. START is occupied for those k cycles, and the first SCAN happens in the cycle after `go` falls.
- Each pass takes (limit) SCAN cycles, plus one cycle per swap, plus 1 PASSEND cycle.
- An already-sorted array of length L reaches DONE (L-1)+1 cycles after leaving START.
- The worst case is a reversed array: sum over passes of (2·limit + 1).
- `done` rises in the cycle DONE is entered and stays high until `go` is asserted again.
- A new `go` in DONE restarts from START. `swaps` holds its value until that START.
- `rd_data` is combinational. After `done` rises, reads return the sorted array with zero latency.
- A reset mid-operation aborts at that edge and returns to IDLE. The array is left partially sorted and is not restored.
- Simultaneous `go`=1 and `wr_en`=1 in IDLE: the write commits and the state moves to START.

## Test plan
- Reset: hold `reset`=0 for 2 cycles, then release.
  - Required: `busy`=0, `done`=0, `swaps`=0, state IDLE.
  - `go`=0 for 5 cycles keeps all outputs at 0.
- Sorted input: load [1,2,3,4], `length`=4, pulse `go` for 1 cycle.
  - Required: `done` rises exactly 4 cycles after the START-exit edge.
  - `swaps`=0 and the array is unchanged.
- Reversed input: load [4,3,2,1], `length`=4.
  - Required: final array [1,2,3,4], `swaps`=6.
  - `busy` is high for 3+3+2+2+1+1 + passes overhead, matching the formula under Timing.
- Signed and stable: load [-1,5,-3,5], `length`=4.
  - Required: final array [-3,-1,5,5], `swaps`=2.
  - The two 5s are never exchanged.
- Degenerate lengths: `length`=0 and `length`=1.
  - Required: DONE is reached on the cycle after `go` falls, `swaps`=0, `busy` never asserted.
- Protection and abort:
  - `wr_en`=1 during SCAN with data 99: the array is unaffected.
  - A second run asserts `reset`=0 in the middle of SCAN: the state is IDLE next cycle and all outputs are 0.
